gf_mul_serial: RTL and testbench
================================

Name: gf_mul_serial

Overview:
- Bit-serial GF(2^M) multiplier for the mul_gf accelerator datapath. It computes a·b mod P(x) using MSB-first shift-and-add with interleaved reduction, one operand bit per cycle.
- It is the stage that drives the accelerator's single-bit state flops (accumulator, operand shift register, counter).
- It presents a start/done handshake to the accelerator controller upstream.

Parameters:
- M, 13, field degree and operand/result width in bits.
- POLY, 13'h001B, reduction polynomial P(x) without the x^M term. Default gives x^13+x^4+x^3+x+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiplication. Sampled only in IDLE or DONE.
- a  input  M  multiplicand. Captured on the accepted start edge.
- b  input  M  multiplier. Captured on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result is valid.
- result  output  M  a·b mod P(x). Held stable until the next accepted start completes.

Behaviour:
- Reset:
  - rst_n low forces asynchronously: state=IDLE, busy=0, done=0, result=0, acc=0, a_reg=0, b_reg=0, cnt=0.
  - Reset mid-RUN abandons the operation. No done pulse follows.
- Registers:
  - a_reg[M-1:0], b_reg[M-1:0], acc[M-1:0].
  - cnt, width $clog2(M).
  - state in {IDLE, RUN, DONE}.
- IDLE:
  - start=1 → a_reg<=a, b_reg<=b, acc<=0, cnt<=M-1, state<=RUN.
  - start=0 → stay in IDLE.
- RUN, one step per edge:
  - sh = {acc[M-2:0],1'b0} ^ (acc[M-1] ? POLY : 0).
  - acc <= sh ^ (b_reg[M-1] ? a_reg : 0).
  - b_reg <= b_reg<<1.
  - cnt <= cnt-1.
  - On the edge where cnt==0: result <= the new acc value (same next-state expression), state<=DONE.
  - start is ignored in RUN; operands are not re-captured.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 → same capture as in IDLE, go to RUN (back-to-back operation, no idle bubble).
  - start=0 → go to IDLE.
- Latency and outputs:
  - start sampled at edge E0 → RUN steps on edges E1..EM → result updates at EM, done high during the cycle after EM.
  - Total is M+1 cycles start-to-done. Issue interval is M+1 cycles.
  - busy = (state==RUN), registered and decoded from state.
  - result changes only at the final RUN edge.
  - done is never high while busy is high.
- Arithmetic:
  - Pure GF(2): XOR only, no carries.
  - Operand bits above M-1 do not exist. Any a, b in 0..2^M-1 is legal, including 0 and 2^M-1.
  - Reduction is applied before adding a_reg at every step, so acc is always < 2^M.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst_n=0 asynchronously mid-cycle, release, hold start=0 for 20 cycles.
  - Required: busy=0, done=0, result=0 immediately and throughout.
- Basic products (M=13, POLY=0x1B):
  - a=0x0001, b=0x0002 → result=0x0002.
  - a=0x1000, b=0x0002 → result=0x001B.
  - a=0x1000, b=0x0004 → result=0x0036.
  - Each: done pulses exactly 14 cycles after the start edge; busy high 13 cycles.
- Identity and zero:
  - a=0x1FFF, b=0x0001 → result=0x1FFF.
  - a=0x0000, b=0x1ABC → result=0x0000.
  - a=0x1ABC, b=0x0000 → result=0x0000.
- Start during RUN:
  - Stimulus: pulse start with a=0x0003, b=0x0003, then hold start=1 with different operands for the whole RUN.
  - Required: result=0x0005. Exactly one done pulse. Then a new operation starts from the DONE cycle with the operands present on that edge.
- Back-to-back:
  - Stimulus: start held high continuously with a different random operand pair each accepted start.
  - Required: done every 14 cycles. Each result matches a software GF(2^13) reference model.
- Reset mid-operation:
  - Stimulus: drop rst_n at RUN step 6.
  - Required: outputs zero at once, no done pulse. A following operation a=0x0002, b=0x1000 → result=0x001B.

Source files
------------

// File: rtl/gf_mul_serial.sv
// Bit-serial GF(2^M) multiplier, MSB-first shift-and-add with interleaved
// reduction. One multiplier bit is consumed per clock; a start/done
// handshake frames each M+1 cycle operation.
module gf_mul_serial #(
  parameter int             M    = 13,
  parameter logic [M-1:0]   POLY = 13'h001B
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] result
);

  localparam int CW = $clog2(M);
  localparam logic [CW-1:0] CNT_INIT = CW'(M - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   a_reg_q, a_reg_d;
  logic [M-1:0]   b_reg_q, b_reg_d;
  logic [M-1:0]   acc_q, acc_d;
  logic [M-1:0]   result_q, result_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   shifted;
  logic [M-1:0]   step;

  // One multiply step: double the accumulator, fold x^M back via POLY, then add a if the multiplier MSB is set
  always_comb begin
    shifted = {acc_q[M-2:0], 1'b0} ^ (acc_q[M-1] ? POLY : '0);
    step    = shifted ^ (b_reg_q[M-1] ? a_reg_q : '0);
  end

  // Next-state logic for the control FSM and the datapath registers
  always_comb begin
    state_d  = state_q;
    a_reg_d  = a_reg_q;
    b_reg_d  = b_reg_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_reg_d = a;
          b_reg_d = b;
          acc_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = step;
        b_reg_d = {b_reg_q[M-2:0], 1'b0};
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d = step;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (start) begin
          a_reg_d = a;
          b_reg_d = b;
          acc_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously so a reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_reg_q  <= '0;
      b_reg_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_reg_q  <= a_reg_d;
      b_reg_q  <= b_reg_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_gf_mul_serial.sv
// Self-checking bench for gf_mul_serial: scoreboard of expected products
// produced by a schoolbook-multiply-then-reduce reference model.
module tb_gf_mul_serial;

  localparam int          M    = 13;
  localparam logic [12:0] POLY = 13'h001B;

  logic        clk   = 1'b0;
  logic        rstN  = 1'b1;
  logic        start = 1'b0;
  logic [12:0] a     = '0;
  logic [12:0] b     = '0;
  logic        busy;
  logic        done;
  logic [12:0] result;

  int checks = 0;
  int fails  = 0;
  logic [12:0] expQ[$];

  gf_mul_serial #(.M(M), .POLY(POLY)) dut (
    .clk    (clk),
    .rst_n  (rstN),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Reference: full carry-less product, then reduce from the top bit down
  function automatic logic [12:0] gfModel(input logic [12:0] x, input logic [12:0] y);
    logic [24:0] p;
    logic [24:0] fullPoly;
    p = '0;
    fullPoly = 25'h2000 | 25'(POLY);
    for (int i = 0; i < 13; i++)
      if (y[i]) p = p ^ (25'(x) << i);
    for (int k = 24; k >= 13; k--)
      if (p[k]) p = p ^ (fullPoly << (k - 13));
    return p[12:0];
  endfunction

  // done and busy must never be high together
  always @(negedge clk) begin
    if (rstN === 1'b1) begin
      checks++;
      if (done === 1'b1 && busy === 1'b1) begin
        fails++;
        $display("[TB] FAIL doneBusyOverlap: done=%b busy=%b, required not both high", done, busy);
      end
    end
  end

  // Drive one start pulse from a falling edge and queue the expected product
  task automatic startOp(input logic [12:0] x, input logic [12:0] y);
    a = x;
    b = y;
    start = 1'b1;
    expQ.push_back(gfModel(x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; cyc counts samples since the start edge
  task automatic waitDone(output int cyc, output int busyCnt, output bit timedOut);
    cyc = 1;
    busyCnt = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busyCnt++;
      @(negedge clk);
      cyc++;
    end
    timedOut = (done !== 1'b1);
  endtask

  task automatic test_reset();
    #12;
    rstN = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 13'h0) begin
      fails++;
      $display("[TB] FAIL resetImmediate: busy=%b done=%b result=%h, required 0 0 0000", busy, done, result);
    end
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 13'h0) begin
        fails++;
        $display("[TB] FAIL idleHold[%0d]: busy=%b done=%b result=%h, required 0 0 0000", i, busy, done, result);
      end
    end
  endtask

  task automatic test_products();
    logic [12:0] va[6] = '{13'h0001, 13'h1000, 13'h1000, 13'h1FFF, 13'h0000, 13'h1ABC};
    logic [12:0] vb[6] = '{13'h0002, 13'h0002, 13'h0004, 13'h0001, 13'h1ABC, 13'h0000};
    logic [12:0] vr[6] = '{13'h0002, 13'h001B, 13'h0036, 13'h1FFF, 13'h0000, 13'h0000};
    logic [12:0] expR;
    int cyc, bc;
    bit to;
    for (int i = 0; i < 6; i++) begin
      startOp(va[i], vb[i]);
      waitDone(cyc, bc, to);
      checks++;
      if (to || cyc != 14) begin
        fails++;
        $display("[TB] FAIL latency[%0d]: done after %0d cycles, required 14", i, cyc);
      end
      checks++;
      if (bc != 13) begin
        fails++;
        $display("[TB] FAIL busyCycles[%0d]: %0d, required 13", i, bc);
      end
      expR = expQ.pop_front();
      checks++;
      if (result !== expR || result !== vr[i]) begin
        fails++;
        $display("[TB] FAIL product[%0d]: result=%h, required %h", i, result, vr[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        fails++;
        $display("[TB] FAIL donePulse[%0d]: done=%b one cycle later, required 0", i, done);
      end
    end
  endtask

  task automatic test_start_during_run();
    logic [12:0] expR;
    int cyc, bc;
    bit to;
    a = 13'h0003;
    b = 13'h0003;
    start = 1'b1;
    expQ.push_back(gfModel(13'h0003, 13'h0003));
    @(negedge clk);
    a = 13'h0123;
    b = 13'h0456;
    waitDone(cyc, bc, to);
    checks++;
    if (to || cyc != 14) begin
      fails++;
      $display("[TB] FAIL runIgnoreLatency: done after %0d cycles, required 14", cyc);
    end
    expR = expQ.pop_front();
    checks++;
    if (result !== 13'h0005 || result !== expR) begin
      fails++;
      $display("[TB] FAIL runIgnoreResult: result=%h, required 0005", result);
    end
    expQ.push_back(gfModel(13'h0123, 13'h0456));
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL doneToRun: done=%b busy=%b, required 0 1", done, busy);
    end
    waitDone(cyc, bc, to);
    checks++;
    if (to || cyc != 14) begin
      fails++;
      $display("[TB] FAIL fromDoneLatency: done after %0d cycles, required 14", cyc);
    end
    expR = expQ.pop_front();
    checks++;
    if (result !== expR) begin
      fails++;
      $display("[TB] FAIL fromDoneResult: result=%h, required %h", result, expR);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [12:0] x, y, expR;
    int cyc;
    x = 13'($urandom_range(0, 8191));
    y = 13'($urandom_range(0, 8191));
    a = x;
    b = y;
    start = 1'b1;
    expQ.push_back(gfModel(x, y));
    for (int i = 0; i < 8; i++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (done !== 1'b1 && cyc < 40);
      checks++;
      if (done !== 1'b1 || cyc != 14) begin
        fails++;
        $display("[TB] FAIL b2bInterval[%0d]: %0d cycles, required 14", i, cyc);
      end
      expR = expQ.pop_front();
      checks++;
      if (result !== expR) begin
        fails++;
        $display("[TB] FAIL b2bResult[%0d]: result=%h, required %h", i, result, expR);
      end
      if (i < 7) begin
        x = 13'($urandom_range(0, 8191));
        y = 13'($urandom_range(0, 8191));
        a = x;
        b = y;
        expQ.push_back(gfModel(x, y));
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2bIdle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, bc;
    bit to;
    a = 13'h1ABC;
    b = 13'h1555;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    rstN = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 13'h0) begin
      fails++;
      $display("[TB] FAIL midReset: busy=%b done=%b result=%h, required 0 0 0000", busy, done, result);
    end
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("[TB] FAIL noDoneAfterReset[%0d]: done=%b busy=%b, required 0 0", i, done, busy);
      end
    end
    startOp(13'h0002, 13'h1000);
    waitDone(cyc, bc, to);
    checks++;
    if (to || result !== 13'h001B || result !== expQ.pop_front()) begin
      fails++;
      $display("[TB] FAIL afterResetOp: result=%h cycles=%0d, required 001B in 14", result, cyc);
    end
  endtask

  // Global time bound in case the DUT wedges
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_products();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
